// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM stage.
// master: the memory stage (drives request, address, store data, enables).
// slave : the data memory (drives ack and load data).
//   dmem_req   request, held until ack
//   dmem_we    1 = store
//   dmem_addr  word-aligned address
//   dmem_wdata lane-replicated store data
//   dmem_be    byte enables (0 on loads)
//   dmem_ack   access completes this cycle
//   dmem_rdata load word, valid with ack
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory stage: LB/LH/LW/LBU/LHU/SB/SH/SW over a req/ack data port,
// pass-through of non-memory results, misalignment trap, registered MEM/WB.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   valid_in .. reg_write_in  EX/MEM slot contents
//   stall            combinational hold request to upstream
//   dmem             data-memory port (master side)
//   wb_*             registered write-back outputs, wb_valid is a pulse
//   misaligned       one-cycle trap pulse, misaligned_addr holds the address
module mem_access_unit (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        rs2_data,
  input  logic [2:0]         funct3,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [4:0]         rd_in,
  input  logic               reg_write_in,
  output logic               stall,
  mem_access_unit_if.master  dmem,
  output logic               wb_valid,
  output logic [31:0]        wb_data,
  output logic [4:0]         wb_rd,
  output logic               wb_reg_write,
  output logic               misaligned,
  output logic [31:0]        misaligned_addr
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q;
  logic        req_q, we_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        regw_q, load_q;
  logic        wb_valid_q, wb_regw_q, mis_q;
  logic [31:0] wb_data_q, mis_addr_q;
  logic [4:0]  wb_rd_q;

  logic        mem_op, is_half, is_word, addr_mis, accept;
  logic [3:0]  st_be_d;
  logic [31:0] st_wdata_d, ld_shift, ld_data_d;
  logic [15:0] ld_half;

  assign mem_op   = valid_in & (mem_read | mem_write);
  assign is_word  = funct3[1];                 // 010, 011, 110, 111
  assign is_half  = (funct3[1:0] == 2'b01);
  assign addr_mis = (is_half & alu_result[0]) | (is_word & (|alu_result[1:0]));
  assign accept   = (state_q == IDLE) & mem_op & ~addr_mis;
  assign stall    = accept | ((state_q == BUSY) & ~dmem.dmem_ack);

  // Store lane steering from the live inputs; captured on acceptance.
  always_comb begin
    st_be_d    = 4'b1111;
    st_wdata_d = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        st_be_d    = 4'b0001 << alu_result[1:0];
        st_wdata_d = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        st_be_d    = 4'b0011 << alu_result[1:0];
        st_wdata_d = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction from the returned word using the latched offset/size.
  assign ld_shift = dmem.dmem_rdata >> {off_q, 3'b000};
  assign ld_half  = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];

  always_comb begin
    ld_data_d = dmem.dmem_rdata;
    case (f3_q[1:0])
      2'b00:   ld_data_d = {{24{~f3_q[2] & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data_d = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      regw_q     <= 1'b0;
      load_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regw_q  <= 1'b0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in && !(mem_read || mem_write)) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= alu_result;
            wb_rd_q    <= rd_in;
            wb_regw_q  <= reg_write_in;
          end else if (mem_op && addr_mis) begin
            mis_q      <= 1'b1;
            mis_addr_q <= alu_result;
          end else if (accept) begin
            state_q <= BUSY;
            req_q   <= 1'b1;
            we_q    <= ~mem_read;            // read wins if both are set
            addr_q  <= alu_result[31:2];
            wdata_q <= st_wdata_d;
            be_q    <= mem_read ? 4'b0000 : st_be_d;
            off_q   <= alu_result[1:0];
            f3_q    <= funct3;
            rd_q    <= rd_in;
            regw_q  <= reg_write_in;
            load_q  <= mem_read;
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= load_q ? ld_data_d : 32'h0;
            wb_rd_q    <= rd_q;
            wb_regw_q  <= load_q & regw_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = {addr_q, 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

  assign wb_valid        = wb_valid_q;
  assign wb_data         = wb_data_q;
  assign wb_rd           = wb_rd_q;
  assign wb_reg_write    = wb_regw_q;
  assign misaligned      = mis_q;
  assign misaligned_addr = mis_addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result, rs2_data;
  logic [2:0]  funct3;
  logic        mem_read, mem_write;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        stall;
  logic        wb_valid, wb_reg_write, misaligned;
  logic [31:0] wb_data, misaligned_addr;
  logic [4:0]  wb_rd;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_mis_addr = 32'h0;

  mem_access_unit_if mif();

  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
    .rs2_data(rs2_data), .funct3(funct3), .mem_read(mem_read),
    .mem_write(mem_write), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .stall(stall), .dmem(mif), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .misaligned(misaligned),
    .misaligned_addr(misaligned_addr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int          sz = size_of(f3);
    int          off = int'(addr % 4);
    logic [31:0] mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    logic [31:0] v = (rdata >> (8 * off)) & mask;
    if (sz < 4 && !f3[2] && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz = size_of(f3);
    int off = int'(addr % 4);
    int be = (sz == 4) ? 15 : (sz == 2) ? (3 << off) : (1 << off);
    return be[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = size_of(f3);
    if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  task automatic do_pass(input logic [31:0] val, input logic [4:0] rd, input logic rw);
    valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = val; rd_in = rd; reg_write_in = rw;
    rs2_data = $urandom; funct3 = 3'($urandom);
    #1 chk("pass_stall", 32'(stall), 0);
    tick();
    valid_in = 1'b0;
    chk("pass_wb_valid", 32'(wb_valid), 1);
    chk("pass_wb_data", wb_data, val);
    chk("pass_wb_rd", 32'(wb_rd), 32'(rd));
    chk("pass_wb_regw", 32'(wb_reg_write), 32'(rw));
    chk("pass_no_req", 32'(mif.dmem_req), 0);
    chk("pass_mis_addr_held", misaligned_addr, last_mis_addr);
  endtask

  task automatic do_mem(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic rw, input logic [31:0] rdata, input int delay);
    int   sz = size_of(f3);
    logic is_mis = (addr % sz) != 0;
    logic load = rd_op;
    valid_in = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
    alu_result = addr; rs2_data = rs2; rd_in = rd; reg_write_in = rw;
    mif.dmem_ack = 1'b0;
    #1;
    if (is_mis) begin
      chk("mis_stall", 32'(stall), 0);
      tick();
      valid_in = 1'b0;
      chk("mis_pulse", 32'(misaligned), 1);
      chk("mis_addr", misaligned_addr, addr);
      chk("mis_wb_valid", 32'(wb_valid), 0);
      chk("mis_no_req", 32'(mif.dmem_req), 0);
      last_mis_addr = addr;
      tick();
      chk("mis_pulse_end", 32'(misaligned), 0);
      return;
    end
    chk("acc_stall", 32'(stall), 1);
    tick();
    for (int k = 0; k <= delay; k++) begin
      // Garbage on the upstream side while busy must be ignored.
      alu_result = $urandom; rs2_data = $urandom; funct3 = 3'($urandom);
      rd_in = 5'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
      chk("busy_req", 32'(mif.dmem_req), 1);
      chk("busy_we", 32'(mif.dmem_we), 32'(!load));
      chk("busy_addr", mif.dmem_addr, {addr[31:2], 2'b00});
      chk("busy_be", 32'(mif.dmem_be), load ? 0 : 32'(model_be(f3, addr)));
      if (!load) chk("busy_wdata", mif.dmem_wdata, model_wdata(f3, rs2));
      chk("busy_wb_valid", 32'(wb_valid), 0);
      if (k < delay) begin
        mif.dmem_ack = 1'b0;
        mif.dmem_rdata = $urandom;
        #1 chk("wait_stall", 32'(stall), 1);
      end else begin
        mif.dmem_ack = 1'b1;
        mif.dmem_rdata = rdata;
        #1 chk("ack_stall", 32'(stall), 0);
      end
      tick();
    end
    mif.dmem_ack = 1'b0; valid_in = 1'b0;
    chk("done_wb_valid", 32'(wb_valid), 1);
    chk("done_wb_data", wb_data, load ? model_load(rdata, f3, addr) : 32'h0);
    chk("done_wb_rd", 32'(wb_rd), 32'(rd));
    chk("done_wb_regw", 32'(wb_reg_write), load ? 32'(rw) : 0);
    chk("done_req_low", 32'(mif.dmem_req), 0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; alu_result = '0; rs2_data = '0; funct3 = '0;
    mem_read = 1'b0; mem_write = 1'b0; rd_in = '0; reg_write_in = 1'b0;
    mif.dmem_ack = 1'b0; mif.dmem_rdata = '0;
    @(negedge clk);
    tick(); tick();
    chk("rst_req", 32'(mif.dmem_req), 0);
    chk("rst_we", 32'(mif.dmem_we), 0);
    chk("rst_addr", mif.dmem_addr, 0);
    chk("rst_wdata", mif.dmem_wdata, 0);
    chk("rst_be", 32'(mif.dmem_be), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_regw", 32'(wb_reg_write), 0);
    chk("rst_mis", 32'(misaligned), 0);
    chk("rst_mis_addr", misaligned_addr, 0);
    rst = 1'b0;
    tick();

    // Directed steps.
    do_pass(32'h0000_1234, 5'd5, 1'b1);
    do_pass(32'hCAFE_0001, 5'd9, 1'b0);                            // back-to-back
    do_mem(1, 0, 3'b000, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_7F01, 0); // LB
    chk("lb_value", wb_data, 32'hFFFF_FF80);
    do_mem(1, 0, 3'b100, 32'h103, 32'h0, 5'd7, 1, 32'h80FF_7F01, 0); // LBU
    chk("lbu_value", wb_data, 32'h0000_0080);
    do_mem(0, 1, 3'b001, 32'h22, 32'hDEAD_BEEF, 5'd3, 1, 32'h0, 0);  // SH
    do_pass(32'h5555_AAAA, 5'd4, 1'b1);
    do_mem(1, 0, 3'b010, 32'h41, 32'h0, 5'd1, 1, 32'h0, 0);          // misaligned LW
    do_mem(1, 0, 3'b010, 32'h80, 32'h0, 5'd2, 1, 32'h1357_9BDF, 3);  // LW, ack +3
    chk("lw_delay_value", wb_data, 32'h1357_9BDF);
    do_mem(1, 1, 3'b101, 32'h1E, 32'h0, 5'd6, 1, 32'h9ABC_1234, 1);  // both set -> LHU

    // Reset while busy, ack in the same cycle.
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h200; rd_in = 5'd8; reg_write_in = 1'b1;
    tick();
    valid_in = 1'b0;
    chk("rstbusy_req", 32'(mif.dmem_req), 1);
    rst = 1'b1; mif.dmem_ack = 1'b1; mif.dmem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("rstbusy_req_low", 32'(mif.dmem_req), 0);
    chk("rstbusy_no_wb", 32'(wb_valid), 0);
    rst = 1'b0; mif.dmem_ack = 1'b0;
    last_mis_addr = 32'h0;
    #1 chk("rstbusy_idle", 32'(stall), 0);
    tick();
    chk("rstbusy_no_wb2", 32'(wb_valid), 0);
    do_pass(32'h0BAD_F00D, 5'd10, 1'b1);

    // Randomized mix checked against the reference model.
    for (int n = 0; n < 300; n++) begin
      int          kind = int'($urandom_range(0, 3));
      logic [2:0]  f3 = 3'($urandom);
      logic [31:0] a = $urandom;
      if (kind == 0) begin
        do_pass($urandom, 5'($urandom), 1'($urandom));
      end else begin
        if ($urandom_range(0, 2) > 0)
          a[1:0] = f3[1] ? 2'b00 : (f3[0] ? {a[1], 1'b0} : a[1:0]);
        do_mem(kind != 2, kind != 1, f3, a, $urandom, 5'($urandom), 1'($urandom),
               $urandom, int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
